// File: rtl/instruction_fetcher.sv
// Fetch front end: owns the PC, issues one icache request at a time and pre-decodes each returned
// word. It hands one instruction per pulse to the decoder and honours ROB back-pressure and redirects.
module instruction_fetcher #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        rob_full,
  input  logic        rob_to_if_jump,
  input  logic [31:0] rob_to_if_jump_PC,
  output logic        if_to_ic_valid,
  output logic [31:0] if_to_ic_addr,
  input  logic        ic_to_if_ready,
  input  logic [31:0] ic_to_if_inst,
  output logic        if_to_dc_ready,
  output logic [31:0] if_to_dc_PC,
  output logic [31:0] if_to_dc_inst,
  output logic [3:0]  if_to_dc_opType,
  output logic [5:0]  if_to_dc_op
);

  localparam logic [3:0] OPT_NONE = 4'd0, OPT_LUI = 4'd1, OPT_AUIPC = 4'd2, OPT_JAL = 4'd3,
                         OPT_JALR = 4'd4, OPT_BR = 4'd5, OPT_LD = 4'd6, OPT_ST = 4'd7,
                         OPT_RI = 4'd8, OPT_RC = 4'd9;

  localparam logic [5:0] OP_NONE = 6'd0, OP_LUI = 6'd1, OP_AUIPC = 6'd2, OP_JAL = 6'd3, OP_JALR = 6'd4,
                         OP_BEQ = 6'd5, OP_BNE = 6'd6, OP_BLT = 6'd7, OP_BGE = 6'd8, OP_BLTU = 6'd9,
                         OP_BGEU = 6'd10, OP_LB = 6'd11, OP_LH = 6'd12, OP_LW = 6'd13, OP_LBU = 6'd14,
                         OP_LHU = 6'd15, OP_SB = 6'd16, OP_SH = 6'd17, OP_SW = 6'd18, OP_ADDI = 6'd19,
                         OP_SLTI = 6'd20, OP_SLTIU = 6'd21, OP_XORI = 6'd22, OP_ORI = 6'd23,
                         OP_ANDI = 6'd24, OP_SLLI = 6'd25, OP_SRLI = 6'd26, OP_SRAI = 6'd27,
                         OP_ADD = 6'd28, OP_SUB = 6'd29, OP_SLL = 6'd30, OP_SLT = 6'd31,
                         OP_SLTU = 6'd32, OP_XOR = 6'd33, OP_SRL = 6'd34, OP_SRA = 6'd35,
                         OP_OR = 6'd36, OP_AND = 6'd37;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_t;

  function automatic logic [3:0] decode_type(input logic [6:0] opcode);
    case (opcode)
      7'b0110111: decode_type = OPT_LUI;
      7'b0010111: decode_type = OPT_AUIPC;
      7'b1101111: decode_type = OPT_JAL;
      7'b1100111: decode_type = OPT_JALR;
      7'b1100011: decode_type = OPT_BR;
      7'b0000011: decode_type = OPT_LD;
      7'b0100011: decode_type = OPT_ST;
      7'b0010011: decode_type = OPT_RI;
      7'b0110011: decode_type = OPT_RC;
      default:    decode_type = OPT_NONE;
    endcase
  endfunction

  // funct7[5] only matters for ADD/SUB, SRL/SRA and SRLI/SRAI.
  function automatic logic [5:0] decode_op(input logic [3:0] op_type, input logic [2:0] f3,
                                           input logic f7b5);
    case (op_type)
      OPT_LUI:   decode_op = OP_LUI;
      OPT_AUIPC: decode_op = OP_AUIPC;
      OPT_JAL:   decode_op = OP_JAL;
      OPT_JALR:  decode_op = OP_JALR;
      OPT_BR:
        case (f3)
          3'b000:  decode_op = OP_BEQ;
          3'b001:  decode_op = OP_BNE;
          3'b100:  decode_op = OP_BLT;
          3'b101:  decode_op = OP_BGE;
          3'b110:  decode_op = OP_BLTU;
          3'b111:  decode_op = OP_BGEU;
          default: decode_op = OP_NONE;
        endcase
      OPT_LD:
        case (f3)
          3'b000:  decode_op = OP_LB;
          3'b001:  decode_op = OP_LH;
          3'b010:  decode_op = OP_LW;
          3'b100:  decode_op = OP_LBU;
          3'b101:  decode_op = OP_LHU;
          default: decode_op = OP_NONE;
        endcase
      OPT_ST:
        case (f3)
          3'b000:  decode_op = OP_SB;
          3'b001:  decode_op = OP_SH;
          3'b010:  decode_op = OP_SW;
          default: decode_op = OP_NONE;
        endcase
      OPT_RI:
        case (f3)
          3'b000:  decode_op = OP_ADDI;
          3'b001:  decode_op = OP_SLLI;
          3'b010:  decode_op = OP_SLTI;
          3'b011:  decode_op = OP_SLTIU;
          3'b100:  decode_op = OP_XORI;
          3'b101:  decode_op = f7b5 ? OP_SRAI : OP_SRLI;
          3'b110:  decode_op = OP_ORI;
          3'b111:  decode_op = OP_ANDI;
          default: decode_op = OP_NONE;
        endcase
      OPT_RC:
        case (f3)
          3'b000:  decode_op = f7b5 ? OP_SUB : OP_ADD;
          3'b001:  decode_op = OP_SLL;
          3'b010:  decode_op = OP_SLT;
          3'b011:  decode_op = OP_SLTU;
          3'b100:  decode_op = OP_XOR;
          3'b101:  decode_op = f7b5 ? OP_SRA : OP_SRL;
          3'b110:  decode_op = OP_OR;
          3'b111:  decode_op = OP_AND;
          default: decode_op = OP_NONE;
        endcase
      default:   decode_op = OP_NONE;
    endcase
  endfunction

  state_t      state_r;
  logic [31:0] pc_r;
  logic [31:0] buf_inst_r;
  logic [3:0]  buf_type_r;
  logic [5:0]  buf_op_r;
  logic [31:0] buf_next_pc_r;
  logic        ic_valid_r;
  logic [31:0] ic_addr_r;
  logic        dc_ready_r;
  logic [31:0] dc_pc_r;
  logic [31:0] dc_inst_r;
  logic [3:0]  dc_type_r;
  logic [5:0]  dc_op_r;

  logic [3:0]  dec_type_s;
  logic [5:0]  dec_op_s;
  logic [31:0] jal_imm_s;
  logic [31:0] next_pc_s;

  // Pre-decode of the word currently returned by the icache and its static next PC.
  always_comb begin
    dec_type_s = decode_type(ic_to_if_inst[6:0]);
    dec_op_s   = decode_op(dec_type_s, ic_to_if_inst[14:12], ic_to_if_inst[30]);
    jal_imm_s  = {{11{ic_to_if_inst[31]}}, ic_to_if_inst[31], ic_to_if_inst[19:12],
                  ic_to_if_inst[20], ic_to_if_inst[30:21], 1'b0};
    if (dec_type_s == OPT_JAL) begin
      next_pc_s = pc_r + jal_imm_s;
    end else begin
      next_pc_s = pc_r + 32'd4;
    end
  end

  // Fetch FSM with registered icache request and decoder payload.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_r       <= IDLE;
      pc_r          <= RESET_PC;
      buf_inst_r    <= 32'd0;
      buf_type_r    <= OPT_NONE;
      buf_op_r      <= OP_NONE;
      buf_next_pc_r <= 32'd0;
      ic_valid_r    <= 1'b0;
      ic_addr_r     <= 32'd0;
      dc_ready_r    <= 1'b0;
      dc_pc_r       <= 32'd0;
      dc_inst_r     <= 32'd0;
      dc_type_r     <= OPT_NONE;
      dc_op_r       <= OP_NONE;
    end else if (rdy_in) begin
      dc_ready_r <= 1'b0;
      if (rob_to_if_jump) begin
        pc_r       <= rob_to_if_jump_PC;
        ic_valid_r <= 1'b0;
        state_r    <= IDLE;
      end else begin
        case (state_r)
          IDLE: begin
            ic_valid_r <= 1'b1;
            ic_addr_r  <= pc_r;
            state_r    <= WAIT;
          end
          WAIT: begin
            if (ic_to_if_ready) begin
              ic_valid_r <= 1'b0;
              if (dec_type_s == OPT_NONE) begin
                pc_r    <= pc_r + 32'd4;
                state_r <= IDLE;
              end else begin
                buf_inst_r    <= ic_to_if_inst;
                buf_type_r    <= dec_type_s;
                buf_op_r      <= dec_op_s;
                buf_next_pc_r <= next_pc_s;
                if (rob_full) begin
                  state_r <= HOLD;
                end else begin
                  dc_ready_r <= 1'b1;
                  dc_pc_r    <= pc_r;
                  dc_inst_r  <= ic_to_if_inst;
                  dc_type_r  <= dec_type_s;
                  dc_op_r    <= dec_op_s;
                  pc_r       <= next_pc_s;
                  state_r    <= IDLE;
                end
              end
            end
          end
          HOLD: begin
            if (!rob_full) begin
              dc_ready_r <= 1'b1;
              dc_pc_r    <= pc_r;
              dc_inst_r  <= buf_inst_r;
              dc_type_r  <= buf_type_r;
              dc_op_r    <= buf_op_r;
              pc_r       <= buf_next_pc_r;
              state_r    <= IDLE;
            end
          end
          default: begin
            ic_valid_r <= 1'b0;
            state_r    <= IDLE;
          end
        endcase
      end
    end
  end

  assign if_to_ic_valid  = ic_valid_r;
  assign if_to_ic_addr   = ic_addr_r;
  assign if_to_dc_ready  = dc_ready_r;
  assign if_to_dc_PC     = dc_pc_r;
  assign if_to_dc_inst   = dc_inst_r;
  assign if_to_dc_opType = dc_type_r;
  assign if_to_dc_op     = dc_op_r;

endmodule

// File: tb/tb_instruction_fetcher.sv
// Directed bench for instruction_fetcher: hand-computed PCs, pre-decode classes and pulse timing.
module tb_instruction_fetcher;

  logic        clk = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic        rob_full = 1'b0;
  logic        rob_to_if_jump = 1'b0;
  logic [31:0] rob_to_if_jump_PC = 32'd0;
  logic        if_to_ic_valid;
  logic [31:0] if_to_ic_addr;
  logic        ic_to_if_ready = 1'b0;
  logic [31:0] ic_to_if_inst = 32'd0;
  logic        if_to_dc_ready;
  logic [31:0] if_to_dc_PC;
  logic [31:0] if_to_dc_inst;
  logic [3:0]  if_to_dc_opType;
  logic [5:0]  if_to_dc_op;

  int checks = 0;
  int errors = 0;

  instruction_fetcher #(.RESET_PC(32'h0)) dut (
    .clk_in            (clk),
    .rst_in            (rst_in),
    .rdy_in            (rdy_in),
    .rob_full          (rob_full),
    .rob_to_if_jump    (rob_to_if_jump),
    .rob_to_if_jump_PC (rob_to_if_jump_PC),
    .if_to_ic_valid    (if_to_ic_valid),
    .if_to_ic_addr     (if_to_ic_addr),
    .ic_to_if_ready    (ic_to_if_ready),
    .ic_to_if_inst     (ic_to_if_inst),
    .if_to_dc_ready    (if_to_dc_ready),
    .if_to_dc_PC       (if_to_dc_PC),
    .if_to_dc_inst     (if_to_dc_inst),
    .if_to_dc_opType   (if_to_dc_opType),
    .if_to_dc_op       (if_to_dc_op)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic pulse(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                       input logic [31:0] op_type, input logic [31:0] op);
    chk({tag, "_ready"}, {31'd0, if_to_dc_ready}, 32'd1);
    chk({tag, "_pc"}, if_to_dc_PC, pc);
    chk({tag, "_inst"}, if_to_dc_inst, inst);
    chk({tag, "_optype"}, {28'd0, if_to_dc_opType}, op_type);
    chk({tag, "_op"}, {26'd0, if_to_dc_op}, op);
  endtask

  // Wait (bounded) for a request, check its address, then answer one cycle later.
  task automatic serve(input string tag, input logic [31:0] exp_addr, input logic [31:0] word);
    int n = 0;
    while (if_to_ic_valid !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    chk({tag, "_req_valid"}, {31'd0, if_to_ic_valid}, 32'd1);
    chk({tag, "_req_addr"}, if_to_ic_addr, exp_addr);
    tick();
    ic_to_if_ready = 1'b1;
    ic_to_if_inst  = word;
    tick();
    ic_to_if_ready = 1'b0;
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    rst_in = 1'b0;
    chk("rst_valid", {31'd0, if_to_ic_valid}, 32'd0);
    chk("rst_dc_ready", {31'd0, if_to_dc_ready}, 32'd0);
    chk("rst_addr", if_to_ic_addr, 32'd0);
    chk("rst_dc_pc", if_to_dc_PC, 32'd0);

    // ADDI at 0
    serve("t1", 32'h0, 32'h00500093);
    pulse("t1", 32'h0, 32'h00500093, 32'd8, 32'd19);
    tick();
    chk("t1_pulse_end", {31'd0, if_to_dc_ready}, 32'd0);

    // SRAI at 4 exercises funct7[5] in the immediate class
    serve("srai", 32'h4, 32'h40105093);
    pulse("srai", 32'h4, 32'h40105093, 32'd8, 32'd27);

    // JAL +16 at 8
    serve("t2", 32'h8, 32'h0100006F);
    pulse("t2", 32'h8, 32'h0100006F, 32'd3, 32'd3);
    tick();
    chk("t2_pulse_end", {31'd0, if_to_dc_ready}, 32'd0);

    // ROB full when SUB returns at 0x18
    rob_full = 1'b1;
    serve("t3", 32'h18, 32'h40208033);
    chk("t3_hold_valid", {31'd0, if_to_ic_valid}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_no_pulse", {31'd0, if_to_dc_ready}, 32'd0);
      tick();
    end
    rob_full = 1'b0;
    tick();
    pulse("t3", 32'h18, 32'h40208033, 32'd9, 32'd29);
    tick();
    chk("t3_single_pulse", {31'd0, if_to_dc_ready}, 32'd0);
    chk("t3_next_valid", {31'd0, if_to_ic_valid}, 32'd1);
    chk("t3_next_addr", if_to_ic_addr, 32'h1C);

    // Redirect coinciding with icache data
    tick();
    ic_to_if_ready    = 1'b1;
    ic_to_if_inst     = 32'h00500093;
    rob_to_if_jump    = 1'b1;
    rob_to_if_jump_PC = 32'h100;
    tick();
    ic_to_if_ready = 1'b0;
    rob_to_if_jump = 1'b0;
    chk("t4_no_pulse", {31'd0, if_to_dc_ready}, 32'd0);
    chk("t4_abort", {31'd0, if_to_ic_valid}, 32'd0);
    tick();
    chk("t4_no_pulse_late", {31'd0, if_to_dc_ready}, 32'd0);
    chk("t4_req_valid", {31'd0, if_to_ic_valid}, 32'd1);
    chk("t4_req_addr", if_to_ic_addr, 32'h100);

    // Freeze for 4 cycles while waiting on the icache
    rdy_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_frz_valid", {31'd0, if_to_ic_valid}, 32'd1);
      chk("t5_frz_addr", if_to_ic_addr, 32'h100);
      chk("t5_frz_dc_pc", if_to_dc_PC, 32'h18);
    end
    rdy_in = 1'b1;
    tick();
    chk("t5_resume_valid", {31'd0, if_to_ic_valid}, 32'd1);
    ic_to_if_ready = 1'b1;
    ic_to_if_inst  = 32'h123450B7;
    tick();
    ic_to_if_ready = 1'b0;
    pulse("t5", 32'h100, 32'h123450B7, 32'd1, 32'd1);

    // Reset while holding
    rob_full = 1'b1;
    serve("t6", 32'h104, 32'h00000013);
    chk("t6_held", {31'd0, if_to_dc_ready}, 32'd0);
    rst_in = 1'b1;
    tick();
    rst_in   = 1'b0;
    rob_full = 1'b0;
    chk("t6_rst_dc_ready", {31'd0, if_to_dc_ready}, 32'd0);
    chk("t6_rst_valid", {31'd0, if_to_ic_valid}, 32'd0);
    chk("t6_rst_dc_pc", if_to_dc_PC, 32'd0);
    tick();
    chk("t6_discarded", {31'd0, if_to_dc_ready}, 32'd0);
    chk("t6_req_addr", if_to_ic_addr, 32'h0);

    // PC wrap from the top of the address space
    rob_to_if_jump    = 1'b1;
    rob_to_if_jump_PC = 32'hFFFFFFFC;
    tick();
    rob_to_if_jump = 1'b0;
    chk("wrap_abort", {31'd0, if_to_ic_valid}, 32'd0);
    serve("wrap", 32'hFFFFFFFC, 32'h00500093);
    pulse("wrap", 32'hFFFFFFFC, 32'h00500093, 32'd8, 32'd19);

    // Unknown opcode at 0: no pulse, falls through to 4
    serve("unk", 32'h0, 32'hFFFFFFFF);
    chk("unk_no_pulse", {31'd0, if_to_dc_ready}, 32'd0);
    serve("unk_next", 32'h4, 32'h00000013);
    pulse("unk_next", 32'h4, 32'h00000013, 32'd8, 32'd19);

    // Backward JAL -16 at 8 wraps below zero
    serve("jalneg", 32'h8, 32'hFF1FF06F);
    pulse("jalneg", 32'h8, 32'hFF1FF06F, 32'd3, 32'd3);
    serve("jalneg_tgt", 32'hFFFFFFF8, 32'h00000013);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
